edge_detector_multi: RTL and testbench

Parametrised multi-channel edge detector for asynchronous external inputs such as buttons, switches and sensor lines. Per channel it provides a synchroniser, a debounce filter, per-channel edge-mode selection, a one-cycle event pulse and a sticky event flag with write-1-to-clear. An OR-reduced interrupt goes to the control FSM or the bus register block.

---
 rtl/edge_det_pkg.sv | 19 +
 rtl/edge_det_channel.sv | 78 +++++++
 rtl/edge_detector_multi.sv | 49 ++++
 tb/tb_edge_detector_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// edge_det_pkg
// Shared definitions for the multi-channel edge detector:
//   edge_mode_e - per-channel edge selection (off / rise / fall / both)
//   cnt_width   - debounce counter width for a given debounce length
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    // Wide enough to hold 0..debounce_cycles without wrapping.
    function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// edge_det_channel
// One input channel: synchroniser chain, debounce filter, registered
// event pulse and sticky write-1-to-clear flag.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   in_raw - asynchronous input line
//   mode   - edge selection (see edge_mode_e)
//   clr    - write-1-to-clear for flag, sampled each cycle
//   level  - debounced, synchronised level
//   pulse  - one-cycle pulse on a qualifying level toggle
//   flag   - sticky event flag
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_raw,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pulse,
    output logic       flag
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;
    logic                   toggle;
    logic                   pulse_next;
    edge_mode_e             mode_e;

    assign s = sync_q[SYNC_STAGES-1];

    // The level toggles on the cycle whose count would reach DEBOUNCE_CYCLES;
    // the new level equals s, so s alone tells the edge direction.
    always_comb begin
        mode_e     = edge_mode_e'(mode);
        toggle     = (s != level) && (cnt_q == CNT_LAST);
        pulse_next = 1'b0;
        case (mode_e)
            MODE_RISE: pulse_next = toggle & s;
            MODE_FALL: pulse_next = toggle & ~s;
            MODE_BOTH: pulse_next = toggle;
            default:   pulse_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            pulse  <= 1'b0;
            flag   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
            if (s == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            pulse <= pulse_next;
            // Set has priority over a simultaneous clear.
            flag  <= (flag & ~clr) | pulse_next;
        end
    end

endmodule

// File: rtl/edge_detector_multi.sv
// edge_detector_multi
// N_CH independent edge-detector channels with an OR-reduced interrupt.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   in_raw - asynchronous channel inputs
//   mode   - per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr    - per-channel write-1-to-clear for flags
//   level  - debounced, synchronised levels
//   pulse  - one-cycle event pulses
//   flags  - sticky event flags
//   irq    - combinational OR of flags
module edge_detector_multi
    import edge_det_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_raw,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   pulse,
    output logic [N_CH-1:0]   flags,
    output logic              irq
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_raw (in_raw[i]),
            .mode   (mode[2*i +: 2]),
            .clr    (clr[i]),
            .level  (level[i]),
            .pulse  (pulse[i]),
            .flag   (flags[i])
        );
    end

    assign irq = |flags;

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb_edge_detector_multi
// Directed tests for edge_detector_multi with default parameters.
module tb_edge_detector_multi;

    logic       clk;
    logic       rst;
    logic [3:0] in_raw;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] flags;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    edge_detector_multi #(
        .N_CH            (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_raw (in_raw),
        .mode   (mode),
        .clr    (clr),
        .level  (level),
        .pulse  (pulse),
        .flags  (flags),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_raw = 4'b0001; mode = 8'h55; clr = 4'b0000;
        #1 rst = 1'b1;
        tick(); tick();
        n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b expected %b", level, 4'b0000); end
        n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL reset_pulse: got %b expected %b", pulse, 4'b0000); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected %b", irq, 1'b0); end
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = (i == 6) ? 4'b0001 : 4'b0000;
            n_checks++; if (level !== exp_v) begin n_fail++; $display("FAIL poweron_level edge %0d: got %b expected %b", i, level, exp_v); end
            n_checks++; if (pulse !== exp_v) begin n_fail++; $display("FAIL poweron_pulse edge %0d: got %b expected %b", i, pulse, exp_v); end
        end
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL poweron_flags: got %b expected %b", flags, 4'b0001); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL poweron_irq: got %b expected %b", irq, 1'b1); end
        tick();
        n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL poweron_pulse_width: got %b expected %b", pulse, 4'b0000); end
        n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL poweron_level_hold: got %b expected %b", level, 4'b0001); end
    endtask

    task automatic test_glitch();
        in_raw = 4'b0011;
        repeat (3) tick();
        in_raw = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL glitch_pulse cycle %0d: got %b expected %b", i, pulse, 4'b0000); end
            n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL glitch_level cycle %0d: got %b expected %b", i, level, 4'b0001); end
        end
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL glitch_flags: got %b expected %b", flags, 4'b0001); end
        in_raw = 4'b0011;
        for (int i = 1; i <= 6; i++) begin
            logic [3:0] exp_l, exp_p;
            tick();
            exp_l = (i == 6) ? 4'b0011 : 4'b0001;
            exp_p = (i == 6) ? 4'b0010 : 4'b0000;
            n_checks++; if (level !== exp_l) begin n_fail++; $display("FAIL stable_level edge %0d: got %b expected %b", i, level, exp_l); end
            n_checks++; if (pulse !== exp_p) begin n_fail++; $display("FAIL stable_pulse edge %0d: got %b expected %b", i, pulse, exp_p); end
        end
        n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL stable_flags: got %b expected %b", flags, 4'b0011); end
        in_raw = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL rise_mode_fall_pulse cycle %0d: got %b expected %b", i, pulse, 4'b0000); end
        end
        n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL rise_mode_fall_level: got %b expected %b", level, 4'b0001); end
        n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL rise_mode_fall_flags: got %b expected %b", flags, 4'b0011); end
    endtask

    task automatic test_modes();
        clr = 4'b1111; tick(); clr = 4'b0000;
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL modes_clear_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL modes_clear_irq: got %b expected %b", irq, 1'b0); end
        mode = 8'b11_10_01_01;
        in_raw = 4'b1101;
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] exp_p;
            tick();
            exp_p = (i == 6) ? 4'b1000 : 4'b0000;
            n_checks++; if (pulse !== exp_p) begin n_fail++; $display("FAIL modes_rise_pulse cycle %0d: got %b expected %b", i, pulse, exp_p); end
        end
        n_checks++; if (level !== 4'b1101) begin n_fail++; $display("FAIL modes_rise_level: got %b expected %b", level, 4'b1101); end
        n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL modes_rise_flags: got %b expected %b", flags, 4'b1000); end
        in_raw = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] exp_p;
            tick();
            exp_p = (i == 6) ? 4'b1100 : 4'b0000;
            n_checks++; if (pulse !== exp_p) begin n_fail++; $display("FAIL modes_fall_pulse cycle %0d: got %b expected %b", i, pulse, exp_p); end
        end
        n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL modes_fall_level: got %b expected %b", level, 4'b0001); end
        n_checks++; if (flags !== 4'b1100) begin n_fail++; $display("FAIL modes_fall_flags: got %b expected %b", flags, 4'b1100); end
    endtask

    task automatic test_clear();
        clr = 4'b1111; tick(); clr = 4'b0000;
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL clear_all_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clear_all_irq: got %b expected %b", irq, 1'b0); end
        mode = 8'b11_10_01_11;
        in_raw = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            logic [3:0] exp_p;
            tick();
            exp_p = (i == 6) ? 4'b0001 : 4'b0000;
            n_checks++; if (pulse !== exp_p) begin n_fail++; $display("FAIL clear_setup_pulse edge %0d: got %b expected %b", i, pulse, exp_p); end
        end
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL clear_setup_flags: got %b expected %b", flags, 4'b0001); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clear_setup_irq: got %b expected %b", irq, 1'b1); end
        clr = 4'b0001; tick(); clr = 4'b0000;
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL w1c_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected %b", irq, 1'b0); end
        in_raw = 4'b0001;
        repeat (5) tick();
        clr = 4'b0001;
        tick();
        n_checks++; if (pulse !== 4'b0001) begin n_fail++; $display("FAIL set_wins_pulse: got %b expected %b", pulse, 4'b0001); end
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL set_wins_flags: got %b expected %b", flags, 4'b0001); end
        clr = 4'b0000;
        tick();
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL set_wins_hold: got %b expected %b", flags, 4'b0001); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b expected %b", irq, 1'b1); end
        clr = 4'b1110; tick(); clr = 4'b0000;
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL clr_other_channels: got %b expected %b", flags, 4'b0001); end
    endtask

    task automatic test_mode_off();
        clr = 4'b1111; tick(); clr = 4'b0000;
        mode = 8'b00_00_00_00;
        in_raw = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL off_pulse cycle %0d: got %b expected %b", i, pulse, 4'b0000); end
            if (i == 5) begin
                n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL off_level_early: got %b expected %b", level, 4'b0001); end
            end
            if (i == 6) begin
                n_checks++; if (level !== 4'b1111) begin n_fail++; $display("FAIL off_level: got %b expected %b", level, 4'b1111); end
            end
        end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL off_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL off_irq: got %b expected %b", irq, 1'b0); end
        in_raw = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL off_fall_pulse cycle %0d: got %b expected %b", i, pulse, 4'b0000); end
        end
        n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL off_fall_level: got %b expected %b", level, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL off_fall_irq: got %b expected %b", irq, 1'b0); end
    endtask

    task automatic test_async_reset();
        mode = 8'h55;
        in_raw = 4'b0010;
        repeat (6) tick();
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL arst_setup_flags: got %b expected %b", flags, 4'b0010); end
        n_checks++; if (level !== 4'b0010) begin n_fail++; $display("FAIL arst_setup_level: got %b expected %b", level, 4'b0010); end
        in_raw = 4'b0011;
        repeat (4) tick();
        #3 rst = 1'b1;
        #1;
        n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL arst_level: got %b expected %b", level, 4'b0000); end
        n_checks++; if (pulse !== 4'b0000) begin n_fail++; $display("FAIL arst_pulse: got %b expected %b", pulse, 4'b0000); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL arst_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %b expected %b", irq, 1'b0); end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = (i == 6) ? 4'b0011 : 4'b0000;
            n_checks++; if (level !== exp_v) begin n_fail++; $display("FAIL arst_relatch_level edge %0d: got %b expected %b", i, level, exp_v); end
            n_checks++; if (pulse !== exp_v) begin n_fail++; $display("FAIL arst_relatch_pulse edge %0d: got %b expected %b", i, pulse, exp_v); end
        end
        n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL arst_relatch_flags: got %b expected %b", flags, 4'b0011); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_modes();
        test_clear();
        test_mode_off();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
